// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: holds the architectural PC, sequences PC+4, takes
// branch/jal/jr redirects (buffering one that arrives during a stall) and
// captures the fetched word into the IF/ID latch.
// Optional macro FETCH_CHECK_EN: flags misaligned or out-of-range fetch
// addresses on adel_d and substitutes a nop for the fetched word.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI  = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic        redirect_sel,
    input  logic [31:0] npc_in,
    input  logic [31:0] jr_target,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic [31:0] instr_d,
    output logic [31:0] pc4_d,
    output logic        valid_d,
    output logic        adel_d
);

    logic [31:0] pc_q, pc_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_t_q, pend_t_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] target;
    logic [31:0] pc_plus4;

`ifdef FETCH_CHECK_EN
    logic ifid_adel_q, ifid_adel_d;
    logic fetch_bad;

    // Fetch address is misaligned or outside instruction memory.
    always_comb begin
        fetch_bad = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI);
    end
`else
    // Range bounds only matter when fetch checking is built in.
    logic unused_range;
    assign unused_range = ^{IMEM_LO, IMEM_HI};
`endif

    // Next-state logic: PC priority redirect > pending > PC+4; stalls hold
    // everything and park any redirect (last one wins).
    always_comb begin
        target       = redirect_sel ? jr_target : npc_in;
        pc_plus4     = pc_q + 32'd4;
        pc_d         = pc_q;
        pend_v_d     = pend_v_q;
        pend_t_d     = pend_t_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
`ifdef FETCH_CHECK_EN
        ifid_adel_d  = ifid_adel_q;
`endif
        if (!stall) begin
            // Delay-slot word is latched even when a redirect is accepted.
            ifid_instr_d = imem_instr;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
`ifdef FETCH_CHECK_EN
            ifid_adel_d  = fetch_bad;
            if (fetch_bad) begin
                ifid_instr_d = 32'h0000_0000;
            end
`endif
            if (redirect_valid) begin
                pc_d = target;
            end else if (pend_v_q) begin
                pc_d = pend_t_q;
            end else begin
                pc_d = pc_plus4;
            end
            pend_v_d = 1'b0;
        end else if (redirect_valid) begin
            pend_v_d = 1'b1;
            pend_t_d = target;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q         <= RESET_PC;
            pend_v_q     <= 1'b0;
            pend_t_q     <= 32'h0000_0000;
            ifid_instr_q <= 32'h0000_0000;
            ifid_pc4_q   <= 32'h0000_0000;
            ifid_valid_q <= 1'b0;
`ifdef FETCH_CHECK_EN
            ifid_adel_q  <= 1'b0;
`endif
        end else begin
            pc_q         <= pc_d;
            pend_v_q     <= pend_v_d;
            pend_t_q     <= pend_t_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
`ifdef FETCH_CHECK_EN
            ifid_adel_q  <= ifid_adel_d;
`endif
        end
    end

    assign pc      = pc_q;
    assign instr_d = ifid_instr_q;
    assign pc4_d   = ifid_pc4_q;
    assign valid_d = ifid_valid_q;
`ifdef FETCH_CHECK_EN
    assign adel_d  = ifid_adel_q;
`else
    assign adel_d  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset, free run, redirects, stall buffering,
// reset priority, PC wrap and (with FETCH_CHECK_EN) the fetch-address check.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic        redirect_sel;
    logic [31:0] npc_in;
    logic [31:0] jr_target;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] instr_d;
    logic [31:0] pc4_d;
    logic        valid_d;
    logic        adel_d;

    int n_checks = 0;
    int n_errors = 0;

    fetch_pc_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_sel   (redirect_sel),
        .npc_in         (npc_in),
        .jr_target      (jr_target),
        .imem_instr     (imem_instr),
        .pc             (pc),
        .instr_d        (instr_d),
        .pc4_d          (pc4_d),
        .valid_d        (valid_d),
        .adel_d         (adel_d)
    );

    always #5 clk = ~clk;

    // Instruction memory model: each address returns a distinct word.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    always_comb imem_instr = word_at(pc);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic set_redir(input logic v, input logic sel, input logic [31:0] npc,
                             input logic [31:0] jr);
        redirect_valid = v;
        redirect_sel   = sel;
        npc_in         = npc;
        jr_target      = jr;
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        set_redir(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state
        tick();
        chk32("rst_pc", pc, 32'h3000);
        chk32("rst_instr", instr_d, 32'h0);
        chk32("rst_pc4", pc4_d, 32'h0);
        chk1("rst_valid", valid_d, 1'b0);
        chk1("rst_adel", adel_d, 1'b0);

        // Free run three cycles
        reset = 1'b1;
        tick();
        chk32("run1_pc", pc, 32'h3004);
        chk32("run1_instr", instr_d, word_at(32'h3000));
        tick();
        chk32("run2_pc", pc, 32'h3008);
        tick();
        chk32("run3_pc", pc, 32'h300C);
        chk32("run3_pc4", pc4_d, 32'h300C);
        chk1("run3_valid", valid_d, 1'b1);
        chk1("run3_adel", adel_d, 1'b0);

        // Re-reset and run to 0x3008, then branch to 0x3100
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk32("pre_br_pc", pc, 32'h3008);
        set_redir(1'b1, 1'b0, 32'h3100, 32'h0);
        tick();
        chk32("br_pc", pc, 32'h3100);
        chk32("br_slot_instr", instr_d, word_at(32'h3008));
        chk32("br_slot_pc4", pc4_d, 32'h300C);
        set_redir(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk32("br_tgt_instr", instr_d, word_at(32'h3100));
        chk32("br_tgt_pc4", pc4_d, 32'h3104);
        chk32("br_next_pc", pc, 32'h3104);

        // Go to 0x3010, stall two cycles with a jr redirect in the first
        set_redir(1'b1, 1'b0, 32'h3010, 32'h0);
        tick();
        chk32("to3010_pc", pc, 32'h3010);
        stall = 1'b1;
        set_redir(1'b1, 1'b1, 32'hDEAD_BEEC, 32'h3200);
        tick();
        chk32("st1_pc", pc, 32'h3010);
        chk32("st1_instr", instr_d, word_at(32'h3104));
        chk32("st1_pc4", pc4_d, 32'h3108);
        set_redir(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk32("st2_pc", pc, 32'h3010);
        stall = 1'b0;
        tick();
        chk32("rel_pc", pc, 32'h3200);
        chk32("rel_instr", instr_d, word_at(32'h3010));
        chk32("rel_pc4", pc4_d, 32'h3014);
        tick();
        chk32("pend_clr_pc", pc, 32'h3204);

        // Two redirects in one stall: last one wins
        stall = 1'b1;
        set_redir(1'b1, 1'b0, 32'h3300, 32'h0);
        tick();
        set_redir(1'b1, 1'b0, 32'h3400, 32'h0);
        tick();
        chk32("two_st_pc", pc, 32'h3204);
        stall = 1'b0;
        set_redir(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk32("two_rel_pc", pc, 32'h3400);
        tick();
        chk32("two_after_pc", pc, 32'h3404);

        // Live redirect beats pending on release
        stall = 1'b1;
        set_redir(1'b1, 1'b0, 32'h3300, 32'h0);
        tick();
        stall = 1'b0;
        set_redir(1'b1, 1'b0, 32'h3500, 32'h0);
        tick();
        chk32("prio_pc", pc, 32'h3500);
        set_redir(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk32("prio_after_pc", pc, 32'h3504);

        // Reset while stalled with a pending redirect
        stall = 1'b1;
        set_redir(1'b1, 1'b0, 32'h3600, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk32("rst_st_pc", pc, 32'h3000);
        chk1("rst_st_valid", valid_d, 1'b0);
        chk32("rst_st_instr", instr_d, 32'h0);
        chk32("rst_st_pc4", pc4_d, 32'h0);
        reset = 1'b1;
        stall = 1'b0;
        set_redir(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk32("rst_st_pend_clr", pc, 32'h3004);
        chk1("rst_st_valid2", valid_d, 1'b1);

        // PC wrap from 0xFFFF_FFFC
        set_redir(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
        tick();
        chk32("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        set_redir(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk32("wrap_pc", pc, 32'h0000_0000);
        chk32("wrap_pc4", pc4_d, 32'h0000_0000);
        chk1("wrap_valid", valid_d, 1'b1);

        // Misaligned fetch at 0x3002
        set_redir(1'b1, 1'b0, 32'h3002, 32'h0);
        tick();
        chk32("mis_pc", pc, 32'h3002);
        set_redir(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk32("mis_pc4", pc4_d, 32'h3006);
        chk1("mis_valid", valid_d, 1'b1);
        chk32("mis_next_pc", pc, 32'h3006);
`ifdef FETCH_CHECK_EN
        chk1("mis_adel", adel_d, 1'b1);
        chk32("mis_instr", instr_d, 32'h0);
        set_redir(1'b1, 1'b0, 32'h6FFC, 32'h0);
        tick();
        set_redir(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk1("hi_edge_adel", adel_d, 1'b0);
        chk32("hi_edge_instr", instr_d, word_at(32'h6FFC));
        tick();
        chk1("above_hi_adel", adel_d, 1'b1);
`else
        chk1("mis_adel", adel_d, 1'b0);
        chk32("mis_instr", instr_d, word_at(32'h3002));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
